// File: rtl/data_mem_access.sv
// Memory-stage load/store unit: checks alignment, issues one word-aligned request
// per access, and returns lane-shifted load data with a one-cycle done pulse.
module data_mem_access #(
  parameter int ADDR_WIDTH        = 32,
  parameter int REG_WIDTH_IN_BYTE = 4,
  parameter int REG_WIDTH_IN_BIT  = REG_WIDTH_IN_BYTE * 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_is_store,
  input  logic [2:0]                  req_funct3,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  input  logic [REG_WIDTH_IN_BIT-1:0] req_wdata,
  output logic                        mem_req,
  input  logic                        mem_gnt,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic                        mem_we,
  output logic [3:0]                  mem_wstrb,
  output logic [REG_WIDTH_IN_BIT-1:0] mem_wdata,
  input  logic                        mem_rvalid,
  input  logic [REG_WIDTH_IN_BIT-1:0] mem_rdata,
  output logic                        busy,
  output logic                        done,
  output logic                        fault,
  output logic [REG_WIDTH_IN_BIT-1:0] read_data,
  output logic [3:0]                  write_width,
  output logic [2:0]                  funct3_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state_reg, state_next;

  logic [2:0]                  funct3_reg;
  logic [1:0]                  lane_reg;
  logic                        is_store_reg;
  logic                        fault_reg;
  logic [ADDR_WIDTH-1:0]       mem_addr_reg;
  logic                        mem_we_reg;
  logic [3:0]                  mem_wstrb_reg;
  logic [REG_WIDTH_IN_BIT-1:0] mem_wdata_reg;
  logic [REG_WIDTH_IN_BIT-1:0] read_data_reg;
  logic [3:0]                  write_width_reg;

  logic [1:0]                  req_size;
  logic                        req_illegal;
  logic                        req_misaligned;
  logic                        req_fault;
  logic [3:0]                  req_strb;
  logic [3:0]                  req_width;
  logic [REG_WIDTH_IN_BIT-1:0] store_lanes;

  assign req_size = req_funct3[1:0];

  always_comb begin
    req_illegal = 1'b1;
    if (req_is_store) begin
      req_illegal = (req_funct3 > 3'd2);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
        default:                                 req_illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    req_misaligned = 1'b0;
    if (req_size == 2'd1) req_misaligned = req_addr[0];
    if (req_size == 2'd2) req_misaligned = (req_addr[1:0] != 2'b00);
  end

  assign req_fault = req_illegal | req_misaligned;

  always_comb begin
    req_strb  = 4'b0000;
    req_width = 4'd4;
    case (req_size)
      2'd0: begin
        req_strb  = 4'b0001 << req_addr[1:0];
        req_width = 4'd1;
      end
      2'd1: begin
        req_strb  = 4'b0011 << req_addr[1:0];
        req_width = 4'd2;
      end
      default: begin
        req_strb  = 4'b1111;
        req_width = 4'd4;
      end
    endcase
    if (!req_is_store) req_strb = 4'b0000;
  end

  // Narrow stores replicate their data across every lane so any strobe pattern picks it up.
  genvar gi;
  generate
    for (gi = 0; gi < REG_WIDTH_IN_BYTE; gi++) begin : g_lane
      assign store_lanes[8*gi +: 8] =
        (req_size == 2'd0) ? req_wdata[7:0] :
        (req_size == 2'd1) ? req_wdata[8*(gi%2) +: 8] :
                             req_wdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      funct3_reg      <= '0;
      lane_reg        <= '0;
      is_store_reg    <= 1'b0;
      fault_reg       <= 1'b0;
      mem_addr_reg    <= '0;
      mem_we_reg      <= 1'b0;
      mem_wstrb_reg   <= '0;
      mem_wdata_reg   <= '0;
      read_data_reg   <= '0;
      write_width_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        funct3_reg      <= req_funct3;
        fault_reg       <= req_fault;
        write_width_reg <= (req_fault || req_is_store) ? 4'd0 : req_width;
        if (!req_fault) begin
          lane_reg      <= req_addr[1:0];
          is_store_reg  <= req_is_store;
          mem_addr_reg  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_we_reg    <= req_is_store;
          mem_wstrb_reg <= req_strb;
          if (req_is_store) mem_wdata_reg <= store_lanes;
        end
      end
      if (state_reg == WAIT && mem_rvalid && !is_store_reg) begin
        read_data_reg <= mem_rdata >> {lane_reg, 3'b000};
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    busy       = 1'b1;
    mem_req    = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = req_fault ? DONE : REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        fault      = fault_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr    = mem_addr_reg;
  assign mem_we      = mem_we_reg;
  assign mem_wstrb   = mem_wstrb_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign read_data   = read_data_reg;
  assign write_width = write_width_reg;
  assign funct3_out  = funct3_reg;

endmodule
